// File: rtl/alu_operand_stage_if.sv
// Handshake/bus bundle for alu_operand_stage.
// master: upstream producer + downstream consumer side (drives requests, out_ready).
// slave : the operand stage itself (drives in_ready and the registered out_* bus).
interface alu_operand_stage_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned SEL_W   = 2
);
  logic                       in_valid;
  logic                       in_ready;
  logic [SEL_W-1:0]           sel;
  logic [NUM_SRC*WIDTH-1:0]   src_flat;
  logic [15:0]                imm;
  logic [1:0]                 ext_mode;
  logic                       flush;
  logic                       out_valid;
  logic                       out_ready;
  logic [WIDTH-1:0]           out_data;
  logic                       out_err;

  modport master (
    output in_valid, sel, src_flat, imm, ext_mode, flush, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, sel, src_flat, imm, ext_mode, flush, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/alu_operand_stage.sv
// Registered operand-select stage for the ALU B input.
// Picks one of NUM_SRC full-width sources or an extended 16-bit immediate and
// holds it in a two-entry skid buffer (main entry M drives the outputs, skid
// entry S absorbs one overflow operand) behind a valid/ready handshake.
// Ports: clk, rst (synchronous, active-high), bus (slave modport: request
// in_valid/sel/src_flat/imm/ext_mode/flush, in_ready; response
// out_valid/out_data/out_err, out_ready).
module alu_operand_stage #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned SEL_W   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_operand_stage_if.slave   bus
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             err;
    logic             valid;
  } entry_t;

  entry_t           m_q, m_d;
  entry_t           s_q, s_d;
  entry_t           cand;
  logic [WIDTH-1:0] imm_sext;
  logic             accept;
  logic             pop;

  // in_ready depends only on registered state, never on out_ready.
  assign accept = bus.in_valid && !s_q.valid;
  assign pop    = m_q.valid && bus.out_ready;

  // Operand formation from the current request.
  always_comb begin
    cand       = '0;
    cand.valid = 1'b1;
    imm_sext   = WIDTH'($signed(bus.imm));
    unique case (bus.ext_mode)
      2'b00: begin
        // Out-of-range select yields zero data flagged as an error.
        cand.err = 1'b1;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
          if (bus.sel == SEL_W'(i)) begin
            cand.data = bus.src_flat[i*WIDTH +: WIDTH];
            cand.err  = 1'b0;
          end
        end
      end
      2'b01: cand.data = imm_sext;
      2'b10: cand.data = WIDTH'(bus.imm);
      2'b11: cand.data = {imm_sext[WIDTH-3:0], 2'b00};
    endcase
  end

  // Buffer next state: flush, then pop-side moves, then accept placement.
  always_comb begin
    m_d = m_q;
    s_d = s_q;
    if (bus.flush) begin
      m_d.valid = 1'b0;
      s_d.valid = 1'b0;
    end else if (pop) begin
      if (s_q.valid) begin
        m_d = s_q;
        s_d = '0;
      end else if (accept) begin
        m_d = cand;
      end else begin
        m_d.valid = 1'b0;
      end
    end else if (accept) begin
      if (m_q.valid) s_d = cand;
      else           m_d = cand;
    end
  end

  // Entry registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q <= '0;
      s_q <= '0;
    end else begin
      m_q <= m_d;
      s_q <= s_d;
    end
  end

  assign bus.in_ready  = !s_q.valid;
  assign bus.out_valid = m_q.valid;
  assign bus.out_data  = m_q.data;
  assign bus.out_err   = m_q.err;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed steps followed by a
// randomised handshake run, checked against a two-deep FIFO queue model.
module tb_alu_operand_stage;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alu_operand_stage_if #(.WIDTH(32), .NUM_SRC(4), .SEL_W(2)) bif ();
  alu_operand_stage_if #(.WIDTH(32), .NUM_SRC(3), .SEL_W(2)) bif3 ();

  alu_operand_stage #(.WIDTH(32), .NUM_SRC(4), .SEL_W(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  alu_operand_stage #(.WIDTH(32), .NUM_SRC(3), .SEL_W(2)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bif3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } exp_t;

  exp_t q[$];

  // Operand as defined by the mode rules, in plain arithmetic.
  function automatic exp_t ref_operand(logic [1:0] mode, int s, logic [127:0] srcs,
                                       logic [15:0] im, int nsrc);
    exp_t r;
    int   simm;
    simm = int'($signed(im));
    r.d  = 32'h0;
    r.e  = 1'b0;
    case (mode)
      2'd0: begin
        if (s < nsrc) r.d = srcs[s*32 +: 32];
        else          r.e = 1'b1;
      end
      2'd1: r.d = 32'(simm);
      2'd2: r.d = 32'(im);
      default: r.d = 32'(simm * 4);
    endcase
    return r;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(string tag);
    chk({tag, "_out_valid"}, 64'(bif.out_valid), 64'(q.size() > 0));
    chk({tag, "_in_ready"},  64'(bif.in_ready),  64'(q.size() < 2));
    if (q.size() > 0) begin
      chk({tag, "_out_data"}, 64'(bif.out_data), 64'(q[0].d));
      chk({tag, "_out_err"},  64'(bif.out_err),  64'(q[0].e));
    end
  endtask

  // One clock: advance the queue model at the edge, then check after it.
  task automatic tick(string tag);
    bit          hold;
    logic [31:0] hd;
    logic        he;
    bit          acc;
    bit          popm;
    exp_t        nxt;
    hold = bif.out_valid && !bif.out_ready && !bif.flush && !rst;
    hd   = bif.out_data;
    he   = bif.out_err;
    @(posedge clk);
    acc  = bif.in_valid && (q.size() < 2);
    popm = (q.size() > 0) && bif.out_ready;
    nxt  = ref_operand(bif.ext_mode, int'(bif.sel), bif.src_flat, bif.imm, 4);
    if (rst || bif.flush) begin
      q.delete();
    end else begin
      if (popm) void'(q.pop_front());
      if (acc)  q.push_back(nxt);
    end
    #1;
    check_outputs(tag);
    if (hold) begin
      chk({tag, "_hold_data"}, 64'(bif.out_data), 64'(hd));
      chk({tag, "_hold_err"},  64'(bif.out_err),  64'(he));
    end
  endtask

  logic [31:0] exp_stream [4];

  initial begin
    checks = 0;
    errors = 0;
    exp_stream[0] = 32'hAAAA0000;
    exp_stream[1] = 32'hBBBB0001;
    exp_stream[2] = 32'hCCCC0002;
    exp_stream[3] = 32'hDDDD0003;

    rst           = 1'b1;
    bif.in_valid  = 1'b0;
    bif.sel       = '0;
    bif.src_flat  = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    bif.imm       = '0;
    bif.ext_mode  = 2'b00;
    bif.flush     = 1'b0;
    bif.out_ready = 1'b1;
    bif3.in_valid  = 1'b0;
    bif3.sel       = '0;
    bif3.src_flat  = {32'h33330002, 32'h22220001, 32'h11110000};
    bif3.imm       = '0;
    bif3.ext_mode  = 2'b00;
    bif3.flush     = 1'b0;
    bif3.out_ready = 1'b1;

    // Reset for two cycles.
    tick("reset");
    tick("reset");
    chk("reset_out_valid", 64'(bif.out_valid), 64'd0);
    chk("reset_out_data",  64'(bif.out_data),  64'd0);
    chk("reset_out_err",   64'(bif.out_err),   64'd0);
    chk("reset_in_ready",  64'(bif.in_ready),  64'd1);
    rst = 1'b0;

    // Streaming register-mode sources.
    for (int i = 0; i < 4; i++) begin
      bif.in_valid = 1'b1;
      bif.sel      = 2'(i);
      tick("stream");
      chk("stream_const", 64'(bif.out_data), 64'(exp_stream[i]));
    end
    bif.in_valid = 1'b0;
    tick("stream_drain");

    // Immediate extension modes.
    bif.imm      = 16'h8004;
    bif.in_valid = 1'b1;
    bif.ext_mode = 2'b01;
    tick("ext01");
    chk("ext01_const", 64'(bif.out_data), 64'h0000_0000_FFFF_8004);
    bif.ext_mode = 2'b10;
    tick("ext10");
    chk("ext10_const", 64'(bif.out_data), 64'h0000_0000_0000_8004);
    bif.ext_mode = 2'b11;
    tick("ext11");
    chk("ext11_const", 64'(bif.out_data), 64'h0000_0000_FFFE_0010);
    chk("ext11_err",   64'(bif.out_err),  64'd0);
    bif.in_valid = 1'b0;
    bif.ext_mode = 2'b00;
    tick("ext_drain");

    // Out-of-range select on the three-source instance.
    bif3.in_valid = 1'b1;
    bif3.sel      = 2'd3;
    tick("oor");
    chk("oor_valid", 64'(bif3.out_valid), 64'd1);
    chk("oor_data",  64'(bif3.out_data),  64'd0);
    chk("oor_err",   64'(bif3.out_err),   64'd1);
    bif3.sel = 2'd1;
    tick("oor_next");
    chk("oor_next_data", 64'(bif3.out_data), 64'h2222_0001);
    chk("oor_next_err",  64'(bif3.out_err),  64'd0);
    bif3.in_valid = 1'b0;
    tick("oor_drain");
    chk("oor_drain_valid", 64'(bif3.out_valid), 64'd0);

    // Backpressure: A, B absorbed, C waits.
    bif.out_ready = 1'b0;
    bif.ext_mode  = 2'b10;
    bif.in_valid  = 1'b1;
    bif.imm       = 16'h000A;
    tick("bp_a");
    chk("bp_ready_after_a", 64'(bif.in_ready), 64'd1);
    bif.imm = 16'h000B;
    tick("bp_b");
    chk("bp_ready_after_b", 64'(bif.in_ready), 64'd0);
    bif.imm = 16'h000C;
    tick("bp_c_blocked");
    chk("bp_hold_a", 64'(bif.out_data), 64'h000A);
    bif.out_ready = 1'b1;
    tick("bp_rel1");
    chk("bp_out_b", 64'(bif.out_data), 64'h000B);
    chk("bp_ready_back", 64'(bif.in_ready), 64'd1);
    tick("bp_rel2");
    chk("bp_out_c", 64'(bif.out_data), 64'h000C);
    bif.in_valid = 1'b0;
    tick("bp_rel3");
    chk("bp_empty", 64'(bif.out_valid), 64'd0);

    // Flush with both entries full and a new operand offered.
    bif.out_ready = 1'b0;
    bif.in_valid  = 1'b1;
    bif.imm       = 16'h00E0;
    tick("fl_e");
    bif.imm = 16'h00F0;
    tick("fl_f");
    bif.imm   = 16'h00D0;
    bif.flush = 1'b1;
    tick("flush");
    chk("flush_out_valid", 64'(bif.out_valid), 64'd0);
    chk("flush_in_ready",  64'(bif.in_ready),  64'd1);
    bif.flush     = 1'b0;
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick("post_flush");
      chk("post_flush_no_d", 64'(bif.out_valid), 64'd0);
    end

    // Randomised handshake against the queue model.
    for (int i = 0; i < 1000; i++) begin
      bif.in_valid  = 1'($urandom_range(0, 1));
      bif.out_ready = 1'($urandom_range(0, 1));
      bif.sel       = 2'($urandom_range(0, 3));
      bif.ext_mode  = 2'($urandom_range(0, 3));
      bif.imm       = 16'($urandom);
      bif.src_flat  = {$urandom, $urandom, $urandom, $urandom};
      bif.flush     = ($urandom_range(0, 39) == 0);
      rst           = (i == 600);
      tick("rand");
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Parametrised, registered operand-select stage for the ALU B input of the datapath. It chooses one of NUM_SRC register/forwarding sources, or an extended 16-bit immediate, and latches the result into a two-entry skid buffer. A valid/ready handshake lets the execute stage stall without dropping operands. It sits between the register-file/forwarding network and the ALU, and adds the buffering and immediate-extension behaviour that a plain combinational source mux lacks.

## Interface
- WIDTH, 32, operand width in bits; must be ≥ 16.
- NUM_SRC, 4, number of full-width sources; must be ≥ 2.
- SEL_W, 2, select width; 2**SEL_W ≥ NUM_SRC is required.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream presents a request this cycle.
- in_ready  out  1  stage can accept a request this cycle.
- sel  in  SEL_W  source index for register mode.
- src_flat  in  NUM_SRC*WIDTH  source i occupies bits [i*WIDTH +: WIDTH].
- imm  in  16  raw instruction immediate.
- ext_mode  in  2  00 register source; 01 sign-extend imm; 10 zero-extend imm; 11 sign-extend imm then shift left 2.
- flush  in  1  discard all buffered and incoming operands.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  WIDTH  selected or extended operand.
- out_err  out  1  the operand came from an out-of-range sel (sel ≥ NUM_SRC in mode 00).

## Operation
- Operand formation (combinational, at the input):
  - Mode 00, sel < NUM_SRC: the operand is src_flat slice sel.
  - Mode 00, sel ≥ NUM_SRC: the operand is 0 and err = 1.
  - Modes 01/10/11: sel is ignored and err = 0.
  - Mode 11 computes {sext(imm), 2'b00} truncated to WIDTH.
- Storage: main entry (M) drives the outputs; skid entry (S) holds one overflow operand. Each entry holds {data, err, valid}.
- in_ready = !S.valid. It is a registered-state function only and never depends on out_ready combinationally.
- Accept: in_valid && in_ready. Pop: out_valid && out_ready.
- Update rules per cycle, evaluated in priority order:
  - rst: M and S are cleared (valid = 0, data = 0, err = 0).
  - flush: M.valid = 0, S.valid = 0. An input accepted in the same cycle is dropped; data fields may retain their values.
  - Pop and S valid: S moves into M, S is cleared. No accept is possible, since in_ready = 0.
  - Pop, S empty, accept: the new operand loads M.
  - Pop, S empty, no accept: M.valid = 0.
  - No pop, M empty, accept: the new operand loads M.
  - No pop, M valid, accept: the new operand loads S.
- Order is strictly FIFO; there is no reordering or merging.
- out_valid = M.valid, out_data = M.data, out_err = M.err.

## Timing
- Reset values: out_valid 0, out_data 0, out_err 0, in_ready 1.
- Latency: an operand accepted at edge N is presented on out_* after edge N, i.e. in cycle N+1.
- Throughput: one operand per cycle while out_ready stays high.
- Backpressure: with out_ready low, two operands are absorbed and in_ready drops in the cycle after the second accept.
- in_ready returns high one cycle after the pop that drains S.
- Simultaneous accept and pop with M valid and S empty: M is replaced, no bubble appears, and S stays empty.
- Flush takes effect at the next edge: out_valid is 0 in the following cycle and in_ready is 1.
- Reset asserted mid-stream overrides everything at that edge, including flush and handshakes.
- Holding: out_data and out_err are stable while out_valid && !out_ready.

## Test plan
- Reset, then streaming: assert rst for 2 cycles, check out_valid=0, out_data=0, in_ready=1. Then stream sel=0..3 with src_flat = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000} and out_ready=1. Expect slices 0..3 on consecutive cycles, one cycle after each accept.
- Extension modes: use imm=16'h8004 with modes 01/10/11. Expect 32'hFFFF8004, 32'h00008004 and 32'hFFFE0010 respectively, with out_err=0.
- Out-of-range select: with NUM_SRC=3, SEL_W=2, send sel=3 in mode 00. Expect out_data=0 and out_err=1; the next request (sel=1) gives out_err=0.
- Backpressure: hold out_ready=0 and offer 3 operands A, B, C. A and B are accepted, and in_ready is 0 from the cycle after B. Release out_ready; expect A, B, C in order with no duplicates and no losses.
- Flush: with M and S both full, assert flush together with in_valid=1 (operand D). Next cycle out_valid=0 and in_ready=1, and D never appears.
- Randomised handshake check: 1000 cycles of random in_valid and out_ready with a scoreboard. Output order must match accept order, and out_data must never change while out_valid && !out_ready.
